// File: rtl/mult_share_if.sv
// Bundle of requester, response and multiplier signals around the shared-multiplier scheduler.
// master is the scheduler's view; slave is the surrounding environment's view.
interface mult_share_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_mc;
  logic [N_REQ*WIDTH-1:0] req_mp;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [2*WIDTH-1:0]     rsp_prod;
  logic                   rsp_err;
  logic                   mult_start;
  logic [WIDTH-1:0]       mult_mc;
  logic [WIDTH-1:0]       mult_mp;
  logic                   mult_busy;
  logic [2*WIDTH-1:0]     mult_prod;

  modport master (
    input  req_valid, req_mc, req_mp, rsp_ready, mult_busy, mult_prod,
    output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mult_start, mult_mc, mult_mp
  );

  modport slave (
    output req_valid, req_mc, req_mp, rsp_ready, mult_busy, mult_prod,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mult_start, mult_mc, mult_mp
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one sequential multiplier between N_REQ requesters,
// with a watchdog that turns a stuck multiplier into an error response.
module mult_share_ctrl #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  mult_share_if.master bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, grant_id;
  logic             grant_any;
  logic [WDW-1:0]   wdog;
  logic             wdog_last, capture, timeout;
  logic [N_REQ-1:0] ready;
  int               cand;
  logic [WIDTH-1:0] mc_arr [N_REQ];
  logic [WIDTH-1:0] mp_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign mc_arr[gi] = bus.req_mc[gi*WIDTH +: WIDTH];
    assign mp_arr[gi] = bus.req_mp[gi*WIDTH +: WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_any && bus.req_valid[IDW'(cand)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(cand);
      end
    end
  end

  // Grant is visible only in IDLE and suppressed while reset is held.
  always_comb begin
    ready = '0;
    if (state == IDLE && grant_any && !rst) ready[grant_id] = 1'b1;
  end
  assign bus.req_ready = ready;

  assign wdog_last = (wdog == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    timeout        = 1'b0;
    bus.mult_start = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state)
      IDLE:      if (grant_any) state_nxt = LAUNCH;
      LAUNCH: begin
        bus.mult_start = 1'b1;
        state_nxt      = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.mult_busy) state_nxt = RUN;
        else if (wdog_last) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      RUN: begin
        if (!bus.mult_busy) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (wdog_last) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      bus.mult_mc  <= '0;
      bus.mult_mp  <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_prod <= '0;
      bus.rsp_err  <= 1'b0;
      wdog         <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        bus.mult_mc <= mc_arr[grant_id];
        bus.mult_mp <= mp_arr[grant_id];
        bus.rsp_id  <= grant_id;
        rr_ptr      <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
      end
      if (state == LAUNCH) wdog <= '0;
      else if (state == WAIT_BUSY || state == RUN) wdog <= wdog + 1'b1;
      if (capture) begin
        bus.rsp_prod <= bus.mult_prod;
        bus.rsp_err  <= 1'b0;
      end else if (timeout) begin
        bus.rsp_prod <= '0;
        bus.rsp_err  <= 1'b1;
      end
    end
  end
endmodule
